// File: rtl/mpq_host_driver.sv
// Host-side initiator for the max-priority-queue engine: resets the queue, streams a
// dataset from the data ROM, then replays the command ROM until the queue reports done.
module mpq_host_driver #(
  parameter int TIMEOUT = 4096,
  parameter int TW      = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  data_len,
  output logic [7:0]  data_addr,
  input  logic [7:0]  data_q,
  output logic [7:0]  cmd_addr,
  input  logic [18:0] cmd_word,
  output logic        mpq_rst,
  output logic        mpq_data_valid,
  output logic [7:0]  mpq_data,
  output logic        mpq_cmd_valid,
  output logic [2:0]  mpq_cmd,
  output logic [7:0]  mpq_index,
  output logic [7:0]  mpq_value,
  input  logic        mpq_busy,
  input  logic        mpq_done,
  output logic        running,
  output logic        finished,
  output logic        error,
  output logic [7:0]  cmds_issued,
  output logic [3:0]  dbg_state
);

  // Handshake: the queue has no ready; mpq_busy low acts as ready. mpq_cmd_valid is a
  // one-cycle strobe raised only after mpq_busy was sampled low in WAITQ, and the queue
  // accepts the command on the edge that ends that strobe.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_QRST     = 4'd1,
    S_STREAM   = 4'd2,
    S_FETCH    = 4'd3,
    S_WAITQ    = 4'd4,
    S_ISSUE    = 4'd5,
    S_GAP      = 4'd6,
    S_WAITDONE = 4'd7,
    S_FINISH   = 4'd8,
    S_ERROR    = 4'd9
  } state_t;

  localparam logic [2:0]    OP_WRITE = 3'd4;
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  state_t        state, next_state;
  logic [7:0]    len_q;
  logic [2:0]    op_q;
  logic          last_addr;
  logic [TW-1:0] tcnt;

  logic start_ok;
  logic timed_out;
  logic rst_d, dvalid_d, cvalid_d, running_d, load_run;

  assign dbg_state = state;
  assign mpq_data  = data_q;
  assign start_ok  = start && (state == S_IDLE || state == S_FINISH || state == S_ERROR);
  assign timed_out = (tcnt == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_FINISH, S_ERROR: begin
        if (start_ok) next_state = (data_len == 8'd0) ? S_ERROR : S_QRST;
      end
      S_QRST:   next_state = S_STREAM;
      S_STREAM: if (data_addr == len_q) next_state = S_FETCH;
      S_FETCH:  next_state = (cmd_word[18:16] > OP_WRITE) ? S_ERROR : S_WAITQ;
      S_WAITQ: begin
        if (!mpq_busy)      next_state = S_ISSUE;
        else if (timed_out) next_state = S_ERROR;
      end
      S_ISSUE: next_state = S_GAP;
      S_GAP: begin
        if (op_q == OP_WRITE) next_state = S_WAITDONE;
        else if (last_addr)   next_state = S_ERROR;
        else                  next_state = S_FETCH;
      end
      S_WAITDONE: begin
        if (mpq_done)       next_state = S_FINISH;
        else if (timed_out) next_state = S_ERROR;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Strobes are registered from next_state so they line up with the state they belong to.
  always_comb begin
    rst_d     = (next_state == S_QRST);
    dvalid_d  = (next_state == S_STREAM);
    cvalid_d  = (next_state == S_ISSUE);
    load_run  = (next_state == S_QRST);
    running_d = !(next_state == S_IDLE || next_state == S_FINISH || next_state == S_ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_addr      <= '0;
      cmd_addr       <= '0;
      mpq_rst        <= 1'b0;
      mpq_data_valid <= 1'b0;
      mpq_cmd_valid  <= 1'b0;
      mpq_cmd        <= '0;
      mpq_index      <= '0;
      mpq_value      <= '0;
      running        <= 1'b0;
      finished       <= 1'b0;
      error          <= 1'b0;
      cmds_issued    <= '0;
      len_q          <= '0;
      op_q           <= '0;
      last_addr      <= 1'b0;
      tcnt           <= '0;
    end else begin
      mpq_rst        <= rst_d;
      mpq_data_valid <= dvalid_d;
      mpq_cmd_valid  <= cvalid_d;
      running        <= running_d;

      if (start_ok)                     finished <= 1'b0;
      else if (next_state == S_FINISH)  finished <= 1'b1;

      if (next_state == S_ERROR) error <= 1'b1;
      else if (start_ok)         error <= 1'b0;

      if (load_run) begin
        len_q       <= data_len;
        data_addr   <= '0;
        cmd_addr    <= '0;
        cmds_issued <= '0;
      end else begin
        // Address runs one ahead of the presented byte to cover the ROM read latency.
        if (state == S_QRST || (state == S_STREAM && next_state == S_STREAM))
          data_addr <= data_addr + 8'd1;
        // Advancing during ISSUE lets FETCH see the next word after one cycle of latency.
        if (state == S_ISSUE && op_q != OP_WRITE && cmd_addr != 8'hff)
          cmd_addr <= cmd_addr + 8'd1;
        if (cvalid_d)
          cmds_issued <= cmds_issued + 8'd1;
      end

      if (state == S_ISSUE) last_addr <= (cmd_addr == 8'hff);
      if (state == S_FETCH) op_q <= cmd_word[18:16];
      if (cvalid_d) begin
        mpq_cmd   <= cmd_word[18:16];
        mpq_index <= cmd_word[15:8];
        mpq_value <= cmd_word[7:0];
      end

      if ((next_state == S_WAITQ && state != S_WAITQ) ||
          (next_state == S_WAITDONE && state != S_WAITDONE))
        tcnt <= '0;
      else if (state == S_WAITQ || state == S_WAITDONE)
        tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mpq_host_driver.sv
// Directed bench for mpq_host_driver: ROM models, a fake queue, and a scoreboard that
// checks every streamed byte and strobed command against expected queues.
module tb_mpq_host_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start;
  logic [7:0]  data_len;
  logic [7:0]  data_addr, data_q, cmd_addr;
  logic [18:0] cmd_word;
  logic        mpq_rst, mpq_data_valid, mpq_cmd_valid;
  logic [7:0]  mpq_data, mpq_index, mpq_value, cmds_issued;
  logic [2:0]  mpq_cmd;
  logic        mpq_busy, mpq_done, running, finished, error;
  logic [3:0]  dbg_state;

  mpq_host_driver dut (
    .clk(clk), .rst(rst), .start(start), .data_len(data_len),
    .data_addr(data_addr), .data_q(data_q), .cmd_addr(cmd_addr), .cmd_word(cmd_word),
    .mpq_rst(mpq_rst), .mpq_data_valid(mpq_data_valid), .mpq_data(mpq_data),
    .mpq_cmd_valid(mpq_cmd_valid), .mpq_cmd(mpq_cmd), .mpq_index(mpq_index),
    .mpq_value(mpq_value), .mpq_busy(mpq_busy), .mpq_done(mpq_done),
    .running(running), .finished(finished), .error(error),
    .cmds_issued(cmds_issued), .dbg_state(dbg_state)
  );

  // Second instance with a short timeout and a queue that never leaves busy.
  logic        start_t;
  logic [7:0]  data_addr_t, cmd_addr_t, mpq_data_t, mpq_index_t, mpq_value_t, cmds_issued_t;
  logic        mpq_rst_t, mpq_data_valid_t, mpq_cmd_valid_t, running_t, finished_t, error_t;
  logic [2:0]  mpq_cmd_t;
  logic [3:0]  dbg_state_t;

  mpq_host_driver #(.TIMEOUT(16), .TW(5)) dut_t (
    .clk(clk), .rst(rst), .start(start_t), .data_len(8'd1),
    .data_addr(data_addr_t), .data_q(8'h55), .cmd_addr(cmd_addr_t), .cmd_word(19'h0),
    .mpq_rst(mpq_rst_t), .mpq_data_valid(mpq_data_valid_t), .mpq_data(mpq_data_t),
    .mpq_cmd_valid(mpq_cmd_valid_t), .mpq_cmd(mpq_cmd_t), .mpq_index(mpq_index_t),
    .mpq_value(mpq_value_t), .mpq_busy(1'b1), .mpq_done(1'b0),
    .running(running_t), .finished(finished_t), .error(error_t),
    .cmds_issued(cmds_issued_t), .dbg_state(dbg_state_t)
  );

  // ---------------- ROM models ----------------
  logic [7:0]  data_rom [256];
  logic [18:0] cmd_rom  [256];
  always @(posedge clk) begin
    data_q   <= data_rom[data_addr];
    cmd_word <= cmd_rom[cmd_addr];
  end

  // ---------------- fake queue ----------------
  int         busy_hold = 0;
  int         busy_cnt  = 0;
  int         qlen      = 0;
  bit         acc_pend  = 1'b0;
  bit         write_pend = 1'b0;
  logic [7:0] qmem [256];

  always @(posedge clk) begin
    if (mpq_rst) begin
      qlen       <= 0;
      busy_cnt   <= 0;
      acc_pend   <= 1'b0;
      write_pend <= 1'b0;
    end else begin
      if (mpq_data_valid) begin
        qmem[qlen[7:0]] <= mpq_data;
        qlen            <= qlen + 1;
      end
      acc_pend <= mpq_cmd_valid;
      if (acc_pend)          busy_cnt <= busy_hold;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (mpq_cmd_valid && mpq_cmd == 3'd4) write_pend <= 1'b1;
    end
  end
  assign mpq_busy = (busy_cnt != 0);
  assign mpq_done = write_pend && (busy_cnt == 0) && !acc_pend;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_data_q [$];
  logic [18:0] exp_cmd_q  [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int data_cnt = 0;
  int rst_cnt  = 0;
  bit prev_rst = 1'b0;
  bit prev_cv  = 1'b0;

  always @(negedge clk) begin
    prev_rst <= mpq_rst;
    prev_cv  <= mpq_cmd_valid;
    if (mpq_rst) begin
      rst_cnt  <= rst_cnt + 1;
      data_cnt <= 0;
    end
    if (prev_rst) chk("data_after_rst", {63'd0, mpq_data_valid}, 64'd1);
    if (mpq_data_valid) begin
      data_cnt <= data_cnt + 1;
      chk("data_exp_avail", {63'd0, exp_data_q.size() != 0}, 64'd1);
      if (exp_data_q.size() != 0) chk("data_byte", {56'd0, mpq_data}, {56'd0, exp_data_q.pop_front()});
    end
    if (prev_cv) chk("no_strobe_after_issue", {63'd0, mpq_cmd_valid}, 64'd0);
    if (mpq_cmd_valid) begin
      chk("busy_at_strobe", {63'd0, mpq_busy}, 64'd0);
      chk("cmd_exp_avail", {63'd0, exp_cmd_q.size() != 0}, 64'd1);
      if (exp_cmd_q.size() != 0)
        chk("cmd_word", {45'd0, mpq_cmd, mpq_index, mpq_value}, {45'd0, exp_cmd_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [7:0] len);
    @(negedge clk);
    data_len = len;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (running && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk(tag, {63'd0, running}, 64'd0);
  endtask

  task automatic load_data(input logic [31:0] bytes, input int len);
    for (int i = 0; i < len; i++) begin
      data_rom[i] = bytes[31-8*i -: 8];
      exp_data_q.push_back(bytes[31-8*i -: 8]);
    end
  endtask

  function automatic logic [31:0] heap4(input logic [31:0] v);
    logic [7:0] h [4];
    logic [7:0] t;
    int j, l, r, m;
    bit go;
    for (int i = 0; i < 4; i++) h[i] = v[31-8*i -: 8];
    for (int i = 1; i >= 0; i--) begin
      j  = i;
      go = 1'b1;
      while (go) begin
        l = 2*j + 1;
        r = 2*j + 2;
        m = j;
        if (l < 4 && h[l] > h[m]) m = l;
        if (r < 4 && h[r] > h[m]) m = r;
        if (m != j) begin
          t = h[j]; h[j] = h[m]; h[m] = t;
          j = m;
        end else go = 1'b0;
      end
    end
    return {h[0], h[1], h[2], h[3]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int rc0, n, wq;
    start   = 1'b0;
    start_t = 1'b0;
    data_len = 8'd0;
    for (int i = 0; i < 256; i++) begin
      data_rom[i] = 8'(i + 1);
      cmd_rom[i]  = 19'h0;
    end

    repeat (3) @(negedge clk);
    chk("reset_outputs", {15'd0, data_addr, cmd_addr, mpq_rst, mpq_data_valid, mpq_cmd_valid,
        mpq_cmd, mpq_index, mpq_value, running, finished, error, cmds_issued}, 64'd0);
    chk("reset_state", {60'd0, dbg_state}, 64'd0);
    rst = 1'b0;

    // Async reset in the middle of a 10-byte stream, after 4 bytes.
    for (int i = 0; i < 10; i++) exp_data_q.push_back(8'(i + 1));
    do_start(8'd10);
    n = 0;
    while (data_cnt < 4 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("stream_reached_4", {32'd0, data_cnt}, 64'd4);
    #1 rst = 1'b1;
    #1;
    chk("midrun_rst_outputs", {15'd0, data_addr, cmd_addr, mpq_rst, mpq_data_valid, mpq_cmd_valid,
        mpq_cmd, mpq_index, mpq_value, running, finished, error, cmds_issued}, 64'd0);
    chk("midrun_rst_state", {60'd0, dbg_state}, 64'd0);
    exp_data_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("no_data_after_rst", {32'd0, data_cnt}, 64'd4);

    // Build and write.
    load_data(32'h03090107, 4);
    cmd_rom[0] = {3'd0, 8'd0, 8'd0};
    cmd_rom[1] = {3'd4, 8'd0, 8'd0};
    exp_cmd_q.push_back(cmd_rom[0]);
    exp_cmd_q.push_back(cmd_rom[1]);
    rc0 = rst_cnt;
    do_start(8'd4);
    wait_idle(300, "build_write_done");
    chk("bw_finished", {63'd0, finished}, 64'd1);
    chk("bw_error", {63'd0, error}, 64'd0);
    chk("bw_cmds_issued", {56'd0, cmds_issued}, 64'd2);
    chk("bw_data_cnt", {32'd0, data_cnt}, 64'd4);
    chk("bw_one_qrst", {32'd0, rst_cnt - rc0}, 64'd1);
    chk("bw_heap_ram", {32'd0, heap4({qmem[0], qmem[1], qmem[2], qmem[3]})}, 64'h09070103);
    chk("bw_cmd_q_empty", {32'd0, exp_cmd_q.size()}, 64'd0);

    // Handshake with 50 busy cycles per command, including INCREASE_VALUE operands.
    busy_hold = 50;
    load_data(32'h03090107, 4);
    cmd_rom[0] = {3'd3, 8'd0, 8'd20};
    cmd_rom[1] = {3'd2, 8'd2, 8'd99};
    cmd_rom[2] = {3'd1, 8'd0, 8'd0};
    cmd_rom[3] = {3'd4, 8'd0, 8'd0};
    for (int i = 0; i < 4; i++) exp_cmd_q.push_back(cmd_rom[i]);
    do_start(8'd4);
    wait_idle(1000, "handshake_done");
    chk("hs_finished", {63'd0, finished}, 64'd1);
    chk("hs_cmds_issued", {56'd0, cmds_issued}, 64'd4);
    chk("hs_last_index", {56'd0, mpq_index}, 64'd0);
    chk("hs_cmd_q_empty", {32'd0, exp_cmd_q.size()}, 64'd0);
    busy_hold = 0;

    // data_len == 0 goes straight to ERROR without a queue reset.
    rc0 = rst_cnt;
    do_start(8'd0);
    chk("len0_error", {63'd0, error}, 64'd1);
    chk("len0_running", {63'd0, running}, 64'd0);
    chk("len0_finished_cleared", {63'd0, finished}, 64'd0);
    chk("len0_state", {60'd0, dbg_state}, 64'd9);
    repeat (5) @(negedge clk);
    #1;
    chk("len0_no_qrst", {32'd0, rst_cnt - rc0}, 64'd0);

    // Illegal opcode at cmd_addr 1.
    load_data(32'h03090000, 2);
    cmd_rom[0] = {3'd0, 8'd0, 8'd0};
    cmd_rom[1] = {3'd6, 8'd1, 8'd1};
    exp_cmd_q.push_back(cmd_rom[0]);
    do_start(8'd2);
    wait_idle(300, "badop_done");
    chk("badop_error", {63'd0, error}, 64'd1);
    chk("badop_cmds_issued", {56'd0, cmds_issued}, 64'd1);
    chk("badop_cmd_addr", {56'd0, cmd_addr}, 64'd1);
    chk("badop_finished", {63'd0, finished}, 64'd0);

    // Stuck busy on the short-timeout instance.
    @(negedge clk);
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    n  = 0;
    wq = 0;
    while (!error_t && n < 200) begin
      @(negedge clk);
      n++;
      if (dbg_state_t == 4'd4) wq++;
    end
    chk("timeout_error", {63'd0, error_t}, 64'd1);
    chk("timeout_waitq_cycles", {32'd0, wq}, 64'd16);
    chk("timeout_cmds_issued", {56'd0, cmds_issued_t}, 64'd0);

    // A fresh start clears the sticky error.
    load_data(32'h03090107, 4);
    cmd_rom[0] = {3'd0, 8'd0, 8'd0};
    cmd_rom[1] = {3'd4, 8'd0, 8'd0};
    exp_cmd_q.push_back(cmd_rom[0]);
    exp_cmd_q.push_back(cmd_rom[1]);
    do_start(8'd4);
    chk("restart_error_cleared", {63'd0, error}, 64'd0);
    chk("restart_running", {63'd0, running}, 64'd1);
    wait_idle(300, "restart_done");
    chk("restart_finished", {63'd0, finished}, 64'd1);

    // 256 BUILD words and no terminator.
    for (int i = 0; i < 256; i++) begin
      cmd_rom[i] = 19'h0;
      exp_cmd_q.push_back(19'h0);
    end
    load_data(32'h2a000000, 1);
    do_start(8'd1);
    wait_idle(3000, "noterm_done");
    chk("noterm_error", {63'd0, error}, 64'd1);
    chk("noterm_cmds_issued", {56'd0, cmds_issued}, 64'd0);
    chk("noterm_cmd_addr", {56'd0, cmd_addr}, 64'd255);
    chk("noterm_finished", {63'd0, finished}, 64'd0);
    chk("noterm_cmd_q_empty", {32'd0, exp_cmd_q.size()}, 64'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
